// File: rtl/hs_pkg.sv
// Shared types and defaults for the hiscore / CPU work-RAM arbiter.
package hs_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      PAUSE_WAIT = 3'd1,
      GRANT      = 3'd2,
      ACCESS     = 3'd3,
      DATA       = 3'd4,
      RELEASE    = 3'd5
   } hs_state_t;

   localparam int HS_AW_DEFAULT      = 11;
   localparam int HS_DW_DEFAULT      = 8;
   localparam int HS_IDLE_TO_DEFAULT = 64;

   // Idle counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/hs_ram_arbiter.sv
// Hands the single-port work RAM to the hiscore engine while the CPU is paused,
// one access at a time, and gives it back to the CPU after an idle timeout.
module hs_ram_arbiter
   import hs_pkg::*;
#(
   parameter int AW      = HS_AW_DEFAULT,
   parameter int DW      = HS_DW_DEFAULT,
   parameter int IDLE_TO = HS_IDLE_TO_DEFAULT
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   input  logic          cpu_we,
   output logic [DW-1:0] cpu_rdata,
   input  logic          hs_req,
   input  logic          hs_we,
   input  logic [AW-1:0] hs_addr,
   input  logic [DW-1:0] hs_wdata,
   output logic [DW-1:0] hs_rdata,
   output logic          hs_ack,
   output logic          pause_req,
   input  logic          cpu_paused,
   output logic          granted,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_we,
   input  logic [DW-1:0] ram_q
);

   localparam logic [7:0] TO_LAST = 8'(IDLE_TO - 1);

   hs_state_t     state_r, state_s;
   logic [7:0]    cnt_r, cnt_s;
   logic          lost_r, lost_s;
   logic          latch_s;
   logic          pause_req_r, granted_r;
   logic          hs_ack_r, hs_ack_d_r;
   logic [DW-1:0] hs_rdata_r;
   logic [AW-1:0] addr_r;
   logic [DW-1:0] wdata_r;
   logic          we_r;

   // Next-state logic; a lost pause lets an in-flight access finish, then releases at once.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      lost_s  = lost_r;
      latch_s = 1'b0;
      case (state_r)
         IDLE: begin
            lost_s = 1'b0;
            if (hs_req) state_s = PAUSE_WAIT;
            else        state_s = IDLE;
         end
         PAUSE_WAIT: begin
            if (!hs_req) begin
               state_s = IDLE;
            end else if (cpu_paused) begin
               state_s = GRANT;
               cnt_s   = 8'd0;
            end else begin
               state_s = PAUSE_WAIT;
            end
         end
         GRANT: begin
            if (!cpu_paused || lost_r) begin
               state_s = RELEASE;
            end else if (hs_req && !hs_ack_d_r) begin
               state_s = ACCESS;
               latch_s = 1'b1;
               cnt_s   = 8'd0;
            end else begin
               cnt_s = sat_inc8(cnt_r);
               if (cnt_r == TO_LAST) state_s = RELEASE;
               else                  state_s = GRANT;
            end
         end
         ACCESS: begin
            if (!cpu_paused) lost_s = 1'b1;
            else             lost_s = lost_r;
            state_s = DATA;
         end
         DATA: begin
            if (!cpu_paused || lost_r) begin
               state_s = RELEASE;
               lost_s  = 1'b0;
            end else begin
               state_s = GRANT;
            end
         end
         RELEASE: begin
            lost_s  = 1'b0;
            state_s = IDLE;
         end
         default: begin
            lost_s  = 1'b0;
            state_s = IDLE;
         end
      endcase
   end

   // State, idle counter and lost-pause flag.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         cnt_r   <= 8'd0;
         lost_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         lost_r  <= lost_s;
      end
   end

   // Registered handshake outputs; ack and read data appear together after DATA.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         pause_req_r <= 1'b0;
         granted_r   <= 1'b0;
         hs_ack_r    <= 1'b0;
         hs_ack_d_r  <= 1'b0;
         hs_rdata_r  <= '0;
      end else begin
         pause_req_r <= (state_s inside {PAUSE_WAIT, GRANT, ACCESS, DATA});
         granted_r   <= (state_s inside {GRANT, ACCESS, DATA});
         hs_ack_r    <= (state_r == DATA);
         hs_ack_d_r  <= hs_ack_r;
         if ((state_r == DATA) && !we_r) hs_rdata_r <= ram_q;
         else                            hs_rdata_r <= hs_rdata_r;
      end
   end

   // Hiscore request capture at acceptance.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         addr_r  <= '0;
         wdata_r <= '0;
         we_r    <= 1'b0;
      end else if (latch_s) begin
         addr_r  <= hs_addr;
         wdata_r <= hs_wdata;
         we_r    <= hs_we;
      end else begin
         addr_r  <= addr_r;
         wdata_r <= wdata_r;
         we_r    <= we_r;
      end
   end

   // RAM port mux; follows the registered grant so reset hands the RAM back immediately.
   always_comb begin
      if (granted_r) begin
         ram_addr  = addr_r;
         ram_wdata = wdata_r;
         ram_we    = (state_r == ACCESS) && we_r;
      end else begin
         ram_addr  = cpu_addr;
         ram_wdata = cpu_wdata;
         ram_we    = cpu_we;
      end
   end

   assign cpu_rdata = ram_q;
   assign hs_rdata  = hs_rdata_r;
   assign hs_ack    = hs_ack_r;
   assign pause_req = pause_req_r;
   assign granted   = granted_r;

endmodule
